// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding, reset address and instruction width for the fetch block
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'd100;
  localparam int INST_W = 32;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry instruction FIFO holding {pc, inst} pairs between fetch and decode
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [31:0]       wpc,
  input  logic [INST_W-1:0] winst,
  output logic [1:0]        count,
  output logic              full,
  output logic [31:0]       head_pc,
  output logic [INST_W-1:0] head_inst
);
  logic [31:0] pcs [2];
  logic [INST_W-1:0] insts [2];
  logic wr, rd;
  assign full = count == 2'(DEPTH);
  assign head_pc = pcs[rd];
  assign head_inst = insts[rd];
  // entries are zeroed on reset so the head reads zero while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wr <= 1'b0;
      rd <= 1'b0;
      pcs[0] <= '0;
      pcs[1] <= '0;
      insts[0] <= '0;
      insts[1] <= '0;
    end else if (flush) begin
      count <= '0;
      wr <= 1'b0;
      rd <= 1'b0;
    end else begin
      if (push) begin
        pcs[wr] <= wpc;
        insts[wr] <= winst;
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: boot/run/halt fetch FSM, PC and fetch counter feeding a two-entry decode buffer
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       im_pc,
  input  logic [INST_W-1:0] im_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc,
  output logic [15:0]       fetch_cnt
);
  state_t state;
  logic [31:0] pc;
  logic [1:0] count;
  logic full, push, pop, redir;
  assign redir = redirect_valid && state != BOOT;
  assign pop = id_valid && id_ready;
  assign push = state == RUN && !halt && !redirect_valid && (!full || pop);
  assign id_valid = count != 2'd0;
  assign im_pc = pc;
  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(redir),
    .wpc(pc), .winst(im_inst), .count(count), .full(full),
    .head_pc(id_pc), .head_inst(id_inst)
  );
  // every state leaves on the halt level; redirect only moves the PC and flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      state <= halt ? HALTED : RUN;
      pc <= redir ? (redirect_pc & ~32'd3) : push ? pc + 32'd4 : pc;
      fetch_cnt <= (push && fetch_cnt != 16'hFFFF) ? fetch_cnt + 16'd1 : fetch_cnt;
    end
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'd100, as the first fetch address after reset (word 25).
REQ-002 The block SHALL expose parameter BUF_DEPTH, default 2, as the instruction buffer depth; only the value 2 is required to be supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 im_pc  output  32  fetch address driven to the instruction memory; the memory decodes pc[7:2].
REQ-006 im_inst  input  32  instruction word returned combinationally for im_pc in the same cycle.
REQ-007 redirect_valid  input  1  branch or jump redirect request.
REQ-008 redirect_pc  input  32  redirect target address.
REQ-009 halt  input  1  level-sensitive fetch stall; while high, no new fetches occur.
REQ-010 id_valid  output  1  buffer head holds a valid instruction for decode.
REQ-011 id_ready  input  1  decode accepts the head this cycle.
REQ-012 id_inst  output  32  instruction at buffer head.
REQ-013 id_pc  output  32  address of id_inst.
REQ-014 fetch_cnt  output  16  count of instructions pushed into the buffer, saturating.

Function
REQ-015 FSM states SHALL be BOOT, RUN and HALTED; reset enters BOOT.
REQ-016 BOOT SHALL last exactly one cycle with no fetch, then go to RUN, or to HALTED if halt=1.
REQ-017 RUN SHALL go to HALTED when halt=1; HALTED SHALL return to RUN when halt=0.
REQ-018 im_pc SHALL equal the PC register in every state.
REQ-019 push SHALL be asserted when state==RUN, halt=0, redirect_valid=0, and (count<2 or pop).
REQ-020 pop SHALL equal id_valid & id_ready.
REQ-021 On push, the block SHALL write {im_pc, im_inst} at the buffer tail and set PC <= PC+4 (32-bit wrap, 32'hFFFFFFFC -> 0).
REQ-022 The buffer SHALL be a 2-entry FIFO; a simultaneous push and pop with count==2 SHALL keep count at 2.
REQ-023 id_valid SHALL be (count!=0); id_inst and id_pc SHALL be the head entry and SHALL hold stable while id_valid=1 and id_ready=0.
REQ-024 Decode-to-fetch latency SHALL be one cycle: an instruction fetched in cycle N is visible on id_* in cycle N+1.
REQ-025 On redirect_valid=1 in any state except BOOT, the block SHALL clear the buffer (count=0) and set PC <= {redirect_pc[31:2],2'b00}, with no push that cycle.
REQ-026 A pop coinciding with a redirect SHALL count as a completed transfer, and the buffer SHALL still be cleared.
REQ-027 Redirect and halt asserted together SHALL apply the redirect and enter or stay in HALTED.
REQ-028 redirect_valid during BOOT SHALL be ignored.
REQ-029 fetch_cnt SHALL increment by 1 on each push and saturate at 16'hFFFF; redirect SHALL not clear it.

Reset
REQ-030 On rst_n=0, the block SHALL asynchronously set state=BOOT, PC=RESET_PC, count=0, fetch_cnt=0, id_valid=0, and buffer pointers to 0.
REQ-031 While in reset, id_inst and id_pc SHALL read 32'h0 and im_pc SHALL read RESET_PC.
REQ-032 Reset asserted mid-operation SHALL discard all buffered instructions; nothing SHALL be presented on id_* until after the next BOOT cycle.

Structure
REQ-033 The FSM state encoding, RESET_PC default and instruction width constant SHALL reside in a shared package, fetch_pkg.
REQ-034 The 2-entry buffer SHALL be the sub-module fetch_buf (push, pop, flush, count, head outputs); the FSM, PC and counter SHALL stay in fetch_ctrl.
REQ-035 fetch_ctrl SHALL connect to the existing instruction memory only through im_pc and im_inst, with no memory copy inside the block.

Verification
REQ-036 Reset release with id_ready=1 and memory words 25..29 loaded SHALL produce no fetch in BOOT, then id_pc values 100, 104, 108, 112, 116 in consecutive cycles starting in cycle 2, with id_inst[31:26] = 6'b100011 for the first four.
REQ-037 With id_ready=0 for 5 cycles, count SHALL reach 2 and im_pc SHALL hold at 108; releasing id_ready SHALL deliver 100 and then 104 with no drop or duplicate.
REQ-038 redirect_valid=1 with redirect_pc=32'd113 while count=2 SHALL make the next cycle show id_valid=0 and im_pc=112, then id_pc=112.
REQ-039 halt=1 for 3 cycles with id_ready=1 SHALL drain the buffer, keep im_pc constant and leave fetch_cnt unchanged; halt=0 SHALL resume at the held PC.
REQ-040 redirect_pc=32'hFFFFFFFC followed by two fetches SHALL produce id_pc values FFFFFFFC and then 00000000.
REQ-041 Asserting rst_n=0 asynchronously mid-stream SHALL immediately give id_valid=0, im_pc=100 and fetch_cnt=0.
